btn_conditioner: RTL

Multi-channel input conditioner that sits directly upstream of the display/scroll controller. It turns raw board switches and push-buttons into clean signals for that controller: `btn`, `direction` and `mode`. Each channel is synchronised into the `clk` domain and debounced. Each channel yields a stable level plus single-cycle press and release pulses. An optional long-press/auto-repeat pulse stream is also available.

---
 rtl/btn_conditioner.sv | 111 +++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel two-flop synchroniser, debounce, and press/release pulses.
// Long-press / auto-repeat pulses are built only when BTN_CONDITIONER_LONG_PRESS_EN is defined.
module btn_conditioner #(
    parameter int N             = 3,
    parameter int DEB_CYCLES    = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 20000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] long_press
);

    localparam int            DW       = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (DEB_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 0) begin : g_bad_params
        $error("btn_conditioner: illegal DEB_CYCLES/HOLD_CYCLES/REPEAT_CYCLES");
    end

    logic [N-1:0]  sync_meta;
    logic [N-1:0]  sync;
    logic [N-1:0]  level_nxt;
    logic [DW-1:0] deb_cnt [N];

    // level flips only after DEB_CYCLES consecutive cycles of disagreement.
    always_comb begin
        level_nxt = level;
        for (int i = 0; i < N; i++) begin
            if (sync[i] != level[i] && deb_cnt[i] == DEB_LAST) begin
                level_nxt[i] = sync[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= '0;
            sync      <= '0;
            level     <= '0;
            press     <= '0;
            rel       <= '0;
            for (int i = 0; i < N; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_meta <= raw_in;
            sync      <= sync_meta;
            level     <= level_nxt;
            press     <= level_nxt & ~level;
            rel       <= ~level_nxt & level;
            for (int i = 0; i < N; i++) begin
                if (sync[i] == level[i] || level_nxt[i] != level[i]) begin
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_CONDITIONER_LONG_PRESS_EN
    localparam int            LP_MAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            LW        = $clog2(LP_MAX + 1);
    localparam logic [LW-1:0] HOLD_LAST = LW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] REP_LAST  = LW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LP_SAT    = LW'(LP_MAX);
    localparam bit            REP_EN    = (REPEAT_CYCLES > 0);

    logic [LW-1:0] lp_cnt [N];
    logic [N-1:0]  repeating;

    // The counter runs only while level is high now and stays high after this edge,
    // so nothing fires in the release cycle; 'repeating' selects hold vs repeat period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_press <= '0;
            repeating  <= '0;
            for (int i = 0; i < N; i++) begin
                lp_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!(level[i] && level_nxt[i])) begin
                    lp_cnt[i]     <= '0;
                    repeating[i]  <= 1'b0;
                    long_press[i] <= 1'b0;
                end else if ((!repeating[i] && lp_cnt[i] == HOLD_LAST) ||
                             (repeating[i] && REP_EN && lp_cnt[i] == REP_LAST)) begin
                    lp_cnt[i]     <= '0;
                    repeating[i]  <= 1'b1;
                    long_press[i] <= 1'b1;
                end else begin
                    long_press[i] <= 1'b0;
                    if (lp_cnt[i] != LP_SAT) begin
                        lp_cnt[i] <= lp_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign long_press = '0;
`endif

endmodule
